// File: rtl/branch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : branch_ctrl_if
// Description : Decode/ALU/PC-facing signal bundle for branch_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
interface branch_ctrl_if #(
    parameter int D     = 12,
    parameter int LUT_W = 4
);
    logic             start;
    logic [D-1:0]     prog_ctr;
    logic             br_valid;
    logic [2:0]       br_op;
    logic [LUT_W-1:0] lut_idx;
    logic             flag_we;
    logic             alu_zero;
    logic             lut_we;
    logic [LUT_W-1:0] lut_waddr;
    logic [D-1:0]     lut_wdata;
    logic             jump_en;
    logic             direction;
    logic [D-1:0]     target;
    logic             done;
    logic             stack_err;

    modport master (
        output start, prog_ctr, br_valid, br_op, lut_idx, flag_we, alu_zero,
               lut_we, lut_waddr, lut_wdata,
        input  jump_en, direction, target, done, stack_err
    );

    modport slave (
        input  start, prog_ctr, br_valid, br_op, lut_idx, flag_we, alu_zero,
               lut_we, lut_waddr, lut_wdata,
        output jump_en, direction, target, done, stack_err
    );
endinterface
`default_nettype wire

// File: rtl/branch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : branch_ctrl
// Description : Branch resolver driving the PC jump interface; jump LUT,
//               zero flag, run/halt FSM. Define BRANCH_CTRL_RAS_EN for the
//               call/return stack.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_ctrl #(
    parameter int D     = 12,
    parameter int LUT_W = 4,
    parameter int SD    = 4
) (
    input  wire logic    clk,
    input  wire logic    reset,
    branch_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    localparam logic [2:0] c_OP_BR   = 3'b001;
    localparam logic [2:0] c_OP_BZ   = 3'b010;
    localparam logic [2:0] c_OP_BNZ  = 3'b011;
    localparam logic [2:0] c_OP_CALL = 3'b100;
    localparam logic [2:0] c_OP_RET  = 3'b101;
    localparam logic [2:0] c_OP_HALT = 3'b110;

    state_t       r_state;
    logic         r_z;
    logic         r_done;
    logic [D-1:0] r_lut [2**LUT_W];

    logic [D-1:0] w_off;
    logic [D-1:0] w_mag;
    logic         w_lut_dir;
    logic         w_jump_en;
    logic         w_dir;
    logic [D-1:0] w_target;
    logic         w_halt;
    logic         w_fault;

`ifdef BRANCH_CTRL_RAS_EN
    localparam int c_SPW = $clog2(SD + 1);
    localparam int c_SIW = (SD > 1) ? $clog2(SD) : 1;

    logic [c_SPW-1:0] r_sp;
    logic [D-1:0]     r_stack [SD];
    logic             r_stack_err;
    logic             w_push;
    logic             w_pop;
    logic [c_SIW-1:0] w_push_idx;
    logic [c_SIW-1:0] w_top_idx;

    assign w_push_idx = c_SIW'(r_sp);
    assign w_top_idx  = c_SIW'(r_sp - 1'b1);
`endif

    // LUT is not reset; a write is visible to lookups from the next cycle.
    always_ff @(posedge clk) begin
        if (bus.lut_we) begin
            r_lut[bus.lut_waddr] <= bus.lut_wdata;
        end
    end

    assign w_off     = r_lut[bus.lut_idx];
    assign w_lut_dir = ~w_off[D-1];
    assign w_mag     = w_off[D-1] ? (~w_off + D'(1)) : w_off;

    always_comb begin
        w_jump_en = 1'b0;
        w_dir     = 1'b1;
        w_target  = '0;
        w_halt    = 1'b0;
        w_fault   = 1'b0;
`ifdef BRANCH_CTRL_RAS_EN
        w_push    = 1'b0;
        w_pop     = 1'b0;
`endif
        if (!reset && !bus.start) begin
            if (r_state == S_HALT) begin
                w_jump_en = 1'b1;
            end else if (r_state == S_RUN && bus.br_valid) begin
                case (bus.br_op)
                    c_OP_BR: begin
                        w_jump_en = 1'b1;
                        w_dir     = w_lut_dir;
                        w_target  = w_mag;
                    end
                    c_OP_BZ, c_OP_BNZ: begin
                        if (r_z == (bus.br_op == c_OP_BZ)) begin
                            w_jump_en = 1'b1;
                            w_dir     = w_lut_dir;
                            w_target  = w_mag;
                        end
                    end
`ifdef BRANCH_CTRL_RAS_EN
                    c_OP_CALL: begin
                        w_jump_en = 1'b1;
                        if (r_sp < c_SPW'(SD)) begin
                            w_push   = 1'b1;
                            w_dir    = w_lut_dir;
                            w_target = w_mag;
                        end else begin
                            w_fault = 1'b1;
                        end
                    end
                    c_OP_RET: begin
                        w_jump_en = 1'b1;
                        if (r_sp != '0) begin
                            w_pop    = 1'b1;
                            w_target = r_stack[w_top_idx] - bus.prog_ctr;
                        end else begin
                            w_fault = 1'b1;
                        end
                    end
`endif
                    c_OP_HALT: begin
                        w_jump_en = 1'b1;
                        w_halt    = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_z         <= 1'b0;
            r_done      <= 1'b0;
`ifdef BRANCH_CTRL_RAS_EN
            r_sp        <= '0;
            r_stack_err <= 1'b0;
`endif
        end else if (bus.start) begin
            r_state     <= S_RUN;
            r_z         <= 1'b0;
            r_done      <= 1'b0;
`ifdef BRANCH_CTRL_RAS_EN
            r_sp        <= '0;
            r_stack_err <= 1'b0;
`endif
        end else begin
            if (bus.flag_we) begin
                r_z <= bus.alu_zero;
            end
            // Halt/fault requests are only raised while running.
            if (w_halt || w_fault) begin
                r_state <= S_HALT;
                r_done  <= 1'b1;
            end
`ifdef BRANCH_CTRL_RAS_EN
            if (w_fault) begin
                r_stack_err <= 1'b1;
            end
            if (w_push) begin
                r_stack[w_push_idx] <= bus.prog_ctr + D'(1);
                r_sp                <= r_sp + 1'b1;
            end
            if (w_pop) begin
                r_sp <= r_sp - 1'b1;
            end
`endif
        end
    end

    assign bus.jump_en   = w_jump_en;
    assign bus.direction = w_dir;
    assign bus.target    = w_target;
    assign bus.done      = r_done;
`ifdef BRANCH_CTRL_RAS_EN
    assign bus.stack_err = r_stack_err;
`else
    assign bus.stack_err = 1'b0;
`endif
endmodule
`default_nettype wire

// File: tb/tb_branch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_ctrl
// Description : Directed bench for branch_ctrl with a per-cycle reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_ctrl;
    localparam int D     = 12;
    localparam int LUT_W = 4;
    localparam int SD    = 4;
    localparam int MASK  = (1 << D) - 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    branch_ctrl_if #(.D(D), .LUT_W(LUT_W)) bus ();
    branch_ctrl #(.D(D), .LUT_W(LUT_W), .SD(SD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Model state: mode 0 = idle, 1 = running, 2 = halted.
    int m_mode;
    bit m_z, m_done, m_err;
    int m_lut [16];
    bit m_lut_ok [16];
    int m_stack [$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (bus.lut_we) begin
            m_lut[bus.lut_waddr]    = int'(bus.lut_wdata);
            m_lut_ok[bus.lut_waddr] = 1'b1;
        end
        if (reset || bus.start) begin
            m_mode = reset ? 0 : 1;
            m_z    = 1'b0;
            m_done = 1'b0;
            m_err  = 1'b0;
            m_stack.delete();
        end else begin
            if (bus.flag_we) m_z = bus.alu_zero;
            if (m_mode == 1 && bus.br_valid) begin
                case (bus.br_op)
                    3'd6: begin m_mode = 2; m_done = 1'b1; end
`ifdef BRANCH_CTRL_RAS_EN
                    3'd4: begin
                        if (m_stack.size() < SD) m_stack.push_back((int'(bus.prog_ctr) + 1) & MASK);
                        else begin m_mode = 2; m_done = 1'b1; m_err = 1'b1; end
                    end
                    3'd5: begin
                        if (m_stack.size() > 0) void'(m_stack.pop_back());
                        else begin m_mode = 2; m_done = 1'b1; m_err = 1'b1; end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        int ej, ed, et, idx, off;
        bit tv, use_lut;
        if (chk_en) begin
            ej = 0; ed = 1; et = 0; tv = 1'b1; use_lut = 1'b0;
            idx = int'(bus.lut_idx);
            if (!(reset || bus.start)) begin
                if (m_mode == 2) ej = 1;
                else if (m_mode == 1 && bus.br_valid) begin
                    case (bus.br_op)
                        3'd1: use_lut = 1'b1;
                        3'd2: use_lut = m_z;
                        3'd3: use_lut = !m_z;
`ifdef BRANCH_CTRL_RAS_EN
                        3'd4: begin
                            if (m_stack.size() < SD) use_lut = 1'b1;
                            else ej = 1;
                        end
                        3'd5: begin
                            ej = 1;
                            if (m_stack.size() > 0) et = (m_stack[$] - int'(bus.prog_ctr)) & MASK;
                        end
`endif
                        3'd6: ej = 1;
                        default: ;
                    endcase
                end
            end
            if (use_lut) begin
                ej = 1;
                if (!m_lut_ok[idx]) tv = 1'b0;
                else begin
                    off = m_lut[idx];
                    if (off >= (1 << (D - 1))) begin ed = 0; et = (1 << D) - off; end
                    else et = off;
                end
            end
            check("model_jump_en", bus.jump_en, ej);
            if (tv) begin
                check("model_direction", bus.direction, ed);
                check("model_target", bus.target, et);
            end
            check("model_done", bus.done, m_done);
            check("model_stack_err", bus.stack_err, m_err);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        bus.start     = 1'b0;
        bus.br_valid  = 1'b0;
        bus.br_op     = 3'd0;
        bus.lut_idx   = '0;
        bus.flag_we   = 1'b0;
        bus.alu_zero  = 1'b0;
        bus.lut_we    = 1'b0;
        bus.lut_waddr = '0;
        bus.lut_wdata = '0;
    endtask

    task automatic op(input logic [2:0] o, input int idx, input bit fwe, input bit az);
        tick();
        idle_in();
        bus.br_valid = 1'b1;
        bus.br_op    = o;
        bus.lut_idx  = LUT_W'(idx);
        bus.flag_we  = fwe;
        bus.alu_zero = az;
        #2;
    endtask

    task automatic wr(input int addr, input int data);
        tick();
        idle_in();
        bus.lut_we    = 1'b1;
        bus.lut_waddr = LUT_W'(addr);
        bus.lut_wdata = D'(data);
        #2;
    endtask

    task automatic do_start();
        tick();
        idle_in();
        bus.start = 1'b1;
        #2;
    endtask

    initial begin
        reset = 1'b1;
        idle_in();
        bus.prog_ctr = '0;
        tick();
        chk_en = 1'b1;
        tick();
        reset = 1'b0;
        #2;
        check("rst_done", bus.done, 0);
        check("rst_stack_err", bus.stack_err, 0);
        check("idle_jump", bus.jump_en, 0);
        repeat (2) op(3'd0, 0, 0, 0);
        op(3'd1, 2, 0, 0);
        check("idle_ignores_br", bus.jump_en, 0);

        wr(1, 12'h020);
        wr(2, 12'hFFB);
        wr(3, 12'h800);
        wr(0, 12'h000);

        do_start();
        check("start_jump", bus.jump_en, 0);
        check("start_dir", bus.direction, 1);
        check("start_target", bus.target, 0);
        op(3'd0, 2, 0, 0);
        check("nop0_jump", bus.jump_en, 0);
        op(3'd7, 2, 0, 0);
        check("nop7_jump", bus.jump_en, 0);

        op(3'd1, 2, 0, 0);
        check("br_neg5_jump", bus.jump_en, 1);
        check("br_neg5_dir", bus.direction, 0);
        check("br_neg5_target", bus.target, 5);
        op(3'd1, 3, 0, 0);
        check("br_min_dir", bus.direction, 0);
        check("br_min_target", bus.target, 12'h800);
        op(3'd1, 0, 0, 0);
        check("br_zero_jump", bus.jump_en, 1);
        check("br_zero_dir", bus.direction, 1);
        check("br_zero_target", bus.target, 0);

        // Rewrite LUT[2] while branching through it: old entry seen this cycle.
        tick();
        idle_in();
        bus.br_valid = 1'b1; bus.br_op = 3'd1; bus.lut_idx = 4'd2;
        bus.lut_we = 1'b1; bus.lut_waddr = 4'd2; bus.lut_wdata = 12'h003;
        #2;
        check("wr_rd_old_dir", bus.direction, 0);
        check("wr_rd_old_target", bus.target, 5);
        op(3'd1, 2, 0, 0);
        check("wr_rd_new_dir", bus.direction, 1);
        check("wr_rd_new_target", bus.target, 3);

        op(3'd2, 1, 1, 1);
        check("bz_old_flag", bus.jump_en, 0);
        op(3'd2, 1, 0, 0);
        check("bz_taken", bus.jump_en, 1);
        check("bz_taken_target", bus.target, 12'h020);
        op(3'd3, 1, 0, 0);
        check("bnz_not_taken", bus.jump_en, 0);
        op(3'd3, 1, 1, 0);
        check("bnz_old_flag", bus.jump_en, 0);
        op(3'd3, 1, 0, 0);
        check("bnz_taken", bus.jump_en, 1);

        tick();
        idle_in();
        bus.br_op = 3'd1; bus.lut_idx = 4'd2;
        #2;
        check("br_not_valid", bus.jump_en, 0);

        op(3'd0, 0, 1, 1);
        do_start();
        op(3'd2, 1, 0, 0);
        check("start_clears_z", bus.jump_en, 0);

`ifdef BRANCH_CTRL_RAS_EN
        bus.prog_ctr = 12'h010;
        op(3'd4, 1, 0, 0);
        check("call_jump", bus.jump_en, 1);
        check("call_target", bus.target, 12'h020);
        bus.prog_ctr = 12'h030;
        op(3'd5, 0, 0, 0);
        check("ret_dir", bus.direction, 1);
        check("ret_target", bus.target, 12'hFE1);

        bus.prog_ctr = 12'h100;
        op(3'd4, 0, 0, 0);
        bus.prog_ctr = 12'h200;
        op(3'd4, 0, 0, 0);
        bus.prog_ctr = 12'h300;
        op(3'd5, 0, 0, 0);
        check("ret_lifo1", bus.target, 12'hF01);
        op(3'd5, 0, 0, 0);
        check("ret_lifo2", bus.target, 12'hE01);

        for (int i = 0; i < 5; i++) begin
            bus.prog_ctr = D'(12'h040 + i);
            op(3'd4, 1, 0, 0);
        end
        check("ovf_jump", bus.jump_en, 1);
        check("ovf_target", bus.target, 0);
        check("ovf_err_lag", bus.stack_err, 0);
        op(3'd1, 2, 0, 0);
        check("ovf_done", bus.done, 1);
        check("ovf_err", bus.stack_err, 1);
        check("ovf_halt_target", bus.target, 0);

        do_start();
        op(3'd5, 0, 0, 0);
        check("udf_jump", bus.jump_en, 1);
        check("udf_target", bus.target, 0);
        op(3'd0, 0, 0, 0);
        check("udf_done", bus.done, 1);
        check("udf_err", bus.stack_err, 1);
`else
        op(3'd4, 1, 0, 0);
        check("call_is_nop", bus.jump_en, 0);
        op(3'd5, 0, 0, 0);
        check("ret_is_nop", bus.jump_en, 0);
        op(3'd0, 0, 0, 0);
        check("no_ras_err", bus.stack_err, 0);
        check("no_ras_done", bus.done, 0);
`endif

        do_start();
        op(3'd6, 0, 0, 0);
        check("halt_jump", bus.jump_en, 1);
        check("halt_target", bus.target, 0);
        check("halt_done_lag", bus.done, 0);
        op(3'd1, 2, 0, 0);
        check("halted_done", bus.done, 1);
        check("halted_jump", bus.jump_en, 1);
        check("halted_target", bus.target, 0);
        do_start();
        check("restart_jump", bus.jump_en, 0);
        op(3'd1, 2, 0, 0);
        check("restart_done", bus.done, 0);
        check("restart_br", bus.jump_en, 1);

        tick();
        idle_in();
        reset = 1'b1;
        bus.start = 1'b1;
        #2;
        check("rst_start_jump", bus.jump_en, 0);
        tick();
        reset = 1'b0;
        idle_in();
        op(3'd1, 2, 0, 0);
        check("rst_wins_idle", bus.jump_en, 0);
        check("rst_wins_done", bus.done, 0);

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
